mac_psum_acc: RTL and testbench
===============================

// Module: mac_psum_acc
// PURPOSE
//   Consumer end of the mac output. Reads one signed bw_psum partial sum per valid cycle
//   and accumulates n_chunk consecutive psums, one per 8-lane chunk, into one wider
//   dot-product result.
//   Each completed result goes into a 2-entry output buffer and is drained over a
//   valid/ready handshake.
//   The mac cannot stall, so the input has no backpressure. A full buffer drops the
//   result and sets a sticky flag.
// PARAMETERS
//   bw_psum   19  width of the signed psum from mac (2*bw+3, bw=8)
//   bw_acc    24  width of the signed accumulator and of out_data; must be >= bw_psum
//   n_chunk   8   psums per result; must be >= 1; counter width = max(1,$clog2(n_chunk))
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        in_psum valid this cycle; upstream delays it 2 cycles to align with mac out
//   in_psum    in   bw_psum  signed partial sum from mac.out
//   out_valid  out  1        buffer head holds a result
//   out_ready  in   1        downstream accepts head when out_valid && out_ready
//   out_data   out  bw_acc   signed result at buffer head
//   chunk_cnt  out  cnt_w    number of psums already folded into the current result
//   sat_flag   out  1        sticky: at least one accumulation saturated
//   drop_flag  out  1        sticky: at least one result was dropped because the buffer was full
// BEHAVIOUR
//   Reset (sync, priority over all else): acc=0, chunk_cnt=0, buffer empty.
//     out_valid=0, out_data=0, sat_flag=0, drop_flag=0.
//     A reset mid-result discards the partial sum and any buffered results.
//   Accumulate, on in_valid=1:
//     - ext = sign-extend(in_psum) to bw_acc+1 bits.
//     - base = 0 if chunk_cnt==0, else acc sign-extended to bw_acc+1 bits.
//     - sum = base + ext, computed at bw_acc+1 bits.
//     - Clamp sum to [-2^(bw_acc-1), 2^(bw_acc-1)-1]. Set sat_flag if clamped.
//     - Once saturated, later adds continue from the clamped value.
//   Counter:
//     - If chunk_cnt==n_chunk-1: the clamped sum is the final result. Push it into the
//       buffer and set chunk_cnt=0. acc keeps the value but the next psum reloads.
//     - Otherwise: acc=clamped sum and chunk_cnt++.
//     - in_valid=0: acc and chunk_cnt hold. Gaps between psums are allowed.
//   Buffer: 2-entry FIFO, registered.
//     - out_valid = not empty; out_data = head, or 0 when empty.
//     - Pop when out_valid && out_ready. out_data/out_valid must stay stable until popped.
//     - A pushed result is visible on out_valid in the cycle after its final in_valid.
//       Latency is 1 clk.
//     - Push and pop in the same cycle: legal at any occupancy. When full, the pop frees
//       the slot, so the push is accepted and the count stays 2.
//     - Push while full with no pop: result discarded, drop_flag=1, buffer unchanged.
//     - Pop while empty: ignored.
//   n_chunk=1: every in_valid produces one result equal to sign-extend(in_psum).
//   No combinational path from in_* to out_*. out_ready reaches only the pop logic.
// TESTING
//   1. Reset, then 8 x in_valid with in_psum=1..8, out_ready=1.
//      -> one cycle after the 8th: out_valid=1, out_data=36; popped next edge.
//   2. Signed: 8 x in_psum=-262144 (0x40000).
//      -> out_data=-2097152 (0xE00000), sat_flag=0.
//   3. bw_acc=20: 8 x in_psum=262143.
//      -> out_data=524287, sat_flag=1 and stays 1 until reset.
//   4. out_ready=0, 3 full results of in_psum=1.
//      -> first two held (out_data=8,8), third dropped, drop_flag=1.
//      -> out_ready=1 then drains exactly 2 results.
//   5. Buffer full; on the 8th psum of the next result also raise out_ready=1.
//      -> no drop, occupancy stays 2, results come out in order.
//   6. 5 psums fed, reset pulsed for 1 cycle, then 8 psums of 2.
//      -> single result 16, chunk_cnt=0 after reset, no stale partial sum.

Source files
------------

// File: rtl/mac_psum_acc.sv
// Folds n_chunk signed mac psums into one saturating bw_acc result and queues it in a 2-entry buffer.
// Result visible 1 clk after its final psum; input never stalls, a full buffer drops the result (sticky drop_flag).
module mac_psum_acc #(
  parameter int bw_psum = 19,
  parameter int bw_acc  = 24,
  parameter int n_chunk = 8,
  localparam int cnt_w  = (n_chunk > 1) ? $clog2(n_chunk) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [bw_psum-1:0]  in_psum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bw_acc-1:0]   out_data,
  output logic [cnt_w-1:0]    chunk_cnt,
  output logic                sat_flag,
  output logic                drop_flag
);

  localparam logic [bw_acc-1:0] acc_max  = {1'b0, {(bw_acc-1){1'b1}}};
  localparam logic [bw_acc-1:0] acc_min  = {1'b1, {(bw_acc-1){1'b0}}};
  localparam logic [cnt_w-1:0]  cnt_last = cnt_w'(n_chunk - 1);

  logic [bw_acc-1:0] acc_q, acc_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;
  logic [bw_acc:0]   ext, base, sum;
  logic              ovf;
  logic [bw_acc-1:0] clamped;
  logic [bw_acc-1:0] mem_q [2];
  logic              rd_q, wr_q;
  logic [1:0]        count_q, count_d;
  logic              sat_q, drop_q;
  logic              last, push, pop, accept;

  always_comb begin
    ext  = {{(bw_acc + 1 - bw_psum){in_psum[bw_psum-1]}}, in_psum};
    // The first psum of a result reloads instead of adding to the previous result.
    base = (cnt_q == '0) ? '0 : {acc_q[bw_acc-1], acc_q};
    sum  = base + ext;
    ovf  = sum[bw_acc] ^ sum[bw_acc-1];
    if (!ovf)             clamped = sum[bw_acc-1:0];
    else if (sum[bw_acc]) clamped = acc_min;
    else                  clamped = acc_max;

    last   = (cnt_q == cnt_last);
    push   = in_valid && last;
    pop    = (count_q != 2'd0) && out_ready;
    // A pop in the same cycle frees a slot even when the buffer is full.
    accept = push && ((count_q != 2'd2) || pop);

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_valid) begin
      acc_d = clamped;
      cnt_d = last ? '0 : cnt_q + cnt_w'(1);
    end
    count_d = count_q + {1'b0, accept} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      count_q  <= 2'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      sat_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (pop) rd_q <= ~rd_q;
      if (accept) begin
        mem_q[wr_q] <= clamped;
        wr_q        <= ~wr_q;
      end
      sat_q  <= sat_q | (in_valid & ovf);
      drop_q <= drop_q | (push & ~accept);
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign chunk_cnt = cnt_q;
  assign sat_flag  = sat_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_mac_psum_acc.sv
// Bench for mac_psum_acc: default instance checked against a queue model, plus bw_acc=20 and n_chunk=1 instances.
module tb_mac_psum_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, out_valid, sat_flag, drop_flag;
  logic [18:0] in_psum;
  logic [23:0] out_data;
  logic [2:0]  chunk_cnt;

  logic        b_valid, b_ready, b_out_valid, b_sat, b_drop;
  logic [18:0] b_psum;
  logic [19:0] b_data;
  logic [2:0]  b_cnt;

  logic        c_valid, c_ready, c_out_valid, c_sat, c_drop;
  logic [18:0] c_psum;
  logic [23:0] c_data;
  logic [0:0]  c_cnt;

  int checks = 0;
  int errors = 0;

  mac_psum_acc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .chunk_cnt(chunk_cnt), .sat_flag(sat_flag), .drop_flag(drop_flag)
  );

  mac_psum_acc #(.bw_psum(19), .bw_acc(20), .n_chunk(8)) dut20 (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_psum(b_psum),
    .out_valid(b_out_valid), .out_ready(b_ready), .out_data(b_data),
    .chunk_cnt(b_cnt), .sat_flag(b_sat), .drop_flag(b_drop)
  );

  mac_psum_acc #(.bw_psum(19), .bw_acc(24), .n_chunk(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(c_valid), .in_psum(c_psum),
    .out_valid(c_out_valid), .out_ready(c_ready), .out_data(c_data),
    .chunk_cnt(c_cnt), .sat_flag(c_sat), .drop_flag(c_drop)
  );

  // Reference model: plain integer running sum and a result queue of at most 2.
  longint m_acc;
  int     m_cnt;
  longint m_q[$];
  bit     m_sat, m_drop;

  function automatic longint clamp(input longint s, input int w);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
  endfunction

  function automatic logic [23:0] m_head();
    longint h;
    if (m_q.size() == 0) return 24'd0;
    h = m_q[0];
    return h[23:0];
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
    b_valid = 1'b0; b_psum = '0; b_ready = 1'b0;
    c_valid = 1'b0; c_psum = '0; c_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    m_acc = 0; m_cnt = 0; m_q.delete(); m_sat = 0; m_drop = 0;
  endtask

  task automatic step(input logic v, input int p, input logic r);
    longint s, c;
    @(negedge clk);
    in_valid = v; in_psum = p[18:0]; out_ready = r;
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    if (v) begin
      s = ((m_cnt == 0) ? 0 : m_acc) + longint'(p);
      c = clamp(s, 24);
      if (c != s) m_sat = 1;
      m_acc = c;
      if (m_cnt == 7) begin
        m_cnt = 0;
        if (m_q.size() < 2) m_q.push_back(c);
        else m_drop = 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 24'd0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
    checks++; if (chunk_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", chunk_cnt); end
    checks++; if ({sat_flag, drop_flag} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {sat_flag, drop_flag}); end
  endtask

  task automatic test_basic_sum();
    reset_dut();
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sum_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 24'd36) begin errors++; $display("FAIL sum_data: got %0d want 36", out_data); end
    checks++; if (chunk_cnt !== 3'd0) begin errors++; $display("FAIL sum_cnt: got %0d want 0", chunk_cnt); end
    step(1'b0, 0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sum_pop: got %b want 0", out_valid); end
  endtask

  task automatic test_signed();
    reset_dut();
    for (int i = 0; i < 8; i++) step(1'b1, -262144, 1'b0);
    checks++; if (out_data !== 24'hE00000) begin errors++; $display("FAIL neg_data: got %h want e00000", out_data); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL neg_sat: got %b want 0", sat_flag); end
  endtask

  task automatic test_saturation();
    int pats [8];
    reset_dut();
    b_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_valid = 1'b1; b_psum = 19'd262143;
      @(negedge clk);
    end
    b_valid = 1'b0;
    checks++; if (b_data !== 20'd524287) begin errors++; $display("FAIL sat_data: got %0d want 524287", b_data); end
    checks++; if (b_sat !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", b_sat); end
    // Clamp at the third add, then continue from the clamped value: 524287 - 262144 = 262143.
    pats = '{262143, 262143, 262143, -262144, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      b_valid = 1'b1; b_psum = pats[i][18:0];
      @(negedge clk);
    end
    b_valid = 1'b0;
    checks++; if (b_data !== 20'd262143) begin errors++; $display("FAIL sat_cont: got %0d want 262143", b_data); end
    checks++; if (b_sat !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", b_sat); end
  endtask

  task automatic test_drop();
    int drained = 0;
    reset_dut();
    for (int i = 0; i < 24; i++) step(1'b1, 1, 1'b0);
    checks++; if (out_data !== 24'd8) begin errors++; $display("FAIL drop_head: got %0d want 8", out_data); end
    checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b want 1", drop_flag); end
    for (int i = 0; i < 4; i++) begin
      if (out_valid) begin
        drained++;
        checks++; if (out_data !== 24'd8) begin errors++; $display("FAIL drop_drain_data: got %0d want 8", out_data); end
      end
      step(1'b0, 0, 1'b1);
    end
    checks++; if (drained != 2) begin errors++; $display("FAIL drop_drained: got %0d want 2", drained); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 8; i++) step(1'b1, 1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 2, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 3, 1'b0);
    step(1'b1, 3, 1'b1);
    checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b want 0", drop_flag); end
    checks++; if (out_data !== 24'd16) begin errors++; $display("FAIL b2b_head1: got %0d want 16", out_data); end
    step(1'b0, 0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'd24) begin errors++; $display("FAIL b2b_head2: got %b/%0d want 1/24", out_valid, out_data); end
    step(1'b0, 0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0);
    checks++; if (chunk_cnt !== 3'd5) begin errors++; $display("FAIL mid_cnt: got %0d want 5", chunk_cnt); end
    reset_dut();
    checks++; if (chunk_cnt !== 3'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", chunk_cnt); end
    for (int i = 0; i < 8; i++) step(1'b1, 2, 1'b0);
    checks++; if (out_data !== 24'd16) begin errors++; $display("FAIL mid_data: got %0d want 16", out_data); end
    step(1'b0, 0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_single: got %b want 0", out_valid); end
  endtask

  task automatic test_single_chunk();
    int p;
    reset_dut();
    c_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p = int'($urandom_range(0, 524287)) - 262144;
      @(negedge clk);
      c_valid = 1'b1; c_psum = p[18:0];
      @(posedge clk); #1;
      checks++; if (c_out_valid !== 1'b1 || c_data !== 24'(p)) begin errors++; $display("FAIL one_data: got %b/%h want 1/%h", c_out_valid, c_data, 24'(p)); end
    end
    @(negedge clk);
    c_valid = 1'b0;
    checks++; if (c_cnt !== 1'b0) begin errors++; $display("FAIL one_cnt: got %0d want 0", c_cnt); end
  endtask

  task automatic test_random();
    int p;
    logic v, r;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      p = int'($urandom_range(0, 524287)) - 262144;
      step(v, p, r);
      checks++; if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", i, out_valid, m_q.size() != 0); end
      checks++; if (out_data !== m_head()) begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", i, out_data, m_head()); end
      checks++; if (chunk_cnt !== 3'(m_cnt)) begin errors++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", i, chunk_cnt, m_cnt); end
      checks++; if ({sat_flag, drop_flag} !== {m_sat, m_drop}) begin errors++; $display("FAIL rnd_flags @%0d: got %b want %b", i, {sat_flag, drop_flag}, {m_sat, m_drop}); end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
    b_valid = 1'b0; b_psum = '0; b_ready = 1'b0;
    c_valid = 1'b0; c_psum = '0; c_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_signed();
    test_saturation();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_single_chunk();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
